key_step_ctrl: RTL
==================

KEY_STEP_CTRL -- requirements
Module: key_step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, clk cycles a synchronized key level must hold before the debounced level changes (10 ms at 25 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 30, frame_tick count from first step to first auto-repeat step.
REQ-003 SHALL have parameter REPEAT_RATE, default 4, frame_tick count between consecutive auto-repeat steps.
REQ-004 SHALL have port clk  input  1  pixel clock (25 MHz); all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports up, down, left, right  input  1 each  raw asynchronous push-button levels, active-high.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse per video frame, synchronous to clk.
REQ-008 SHALL have ports step_up, step_down, step_left, step_right  output  1 each  one-cycle move-request pulses to the logo mover.
REQ-009 SHALL have port key_level  output  4  debounced levels {up,down,left,right}, MSB = up.

Function
REQ-010 SHALL pass each raw key through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep one debounce counter per key, clearing it whenever the synchronized level equals the debounced level.
REQ-012 SHALL toggle the debounced level when the counter reaches DEBOUNCE_CYCLES-1 with the synchronized level still differing, clearing the counter in that same cycle.
REQ-013 SHALL run one FSM per key with states IDLE, HOLD, REPEAT.
REQ-014 IDLE -> HOLD on a debounced rising edge; the step pulse SHALL assert in the cycle after the debounced level rises, for exactly one cycle.
REQ-015 HOLD SHALL count frame_tick pulses; at the REPEAT_DELAY-th tick SHALL emit one step pulse, clear the count and enter REPEAT.
REQ-016 REPEAT SHALL emit one step pulse on every REPEAT_RATE-th frame_tick, clearing the count on each pulse.
REQ-017 Any state SHALL return to IDLE with the count cleared in the cycle after the debounced level falls; no step pulse is emitted on release.
REQ-018 Tick counters SHALL be 8 bits wide and SHALL saturate, never wrap.
REQ-019 When up and down are both debounced-high, step_up and step_down SHALL both be forced low; left/right SHALL be handled likewise; the FSMs keep running.
REQ-020 A step pulse SHALL never exceed one cycle, and steps of the same key SHALL be at least one frame apart, except the first pulse.

Reset
REQ-021 While rst is low, all synchronizer flops, debounced levels, counters and outputs SHALL be 0, and every FSM SHALL be in IDLE.
REQ-022 Reset asserted mid-hold SHALL take effect immediately; after release, a key still held SHALL produce a first step only after a full debounce interval.
REQ-023 Reset deassertion SHALL be consumed synchronously; no step pulse in the first cycle after release.

Configuration
REQ-024 Macro KEY_REPEAT_EN defined: REQ-015/016 auto-repeat SHALL be present.
REQ-025 Macro KEY_REPEAT_EN undefined: HOLD SHALL wait for release with no further pulses, REPEAT SHALL not exist, and REPEAT_DELAY and REPEAT_RATE SHALL be ignored.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2)
REQ-026 up glitches high for 3 cycles, then low -> key_level[3] stays 0, no step_up.
REQ-027 up held steady from cycle 0 -> key_level[3] rises at cycle 6 (2 sync + 4 debounce), step_up high only in cycle 7.
REQ-028 KEY_REPEAT_EN defined, right held through 9 frame_ticks -> step_right pulses: initial, tick 3, tick 5, tick 7, tick 9 (5 total).
REQ-029 up and down pressed together and held -> no step_up or step_down; release down -> step_up repeats continue on up's schedule.
REQ-030 rst driven low during REPEAT on left -> outputs 0 at once; rst high with left held -> next step_left 7 cycles after release (2 sync + 4 debounce + 1), then no pulse before frame_tick 3.
REQ-031 KEY_REPEAT_EN undefined, left held 20 frame_ticks -> exactly one step_left pulse.

Source files
------------

// File: rtl/key_step_ctrl.sv
// Debounced 4-key step generator: 2-flop sync, per-key debounce, per-key IDLE/HOLD(/REPEAT) FSM.
// First step one cycle after the debounced rise; frame-paced auto-repeat only when KEY_REPEAT_EN is defined.
module key_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 30,
    parameter int unsigned REPEAT_RATE     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       frame_tick,
    output logic       step_up,
    output logic       step_down,
    output logic       step_left,
    output logic       step_right,
    output logic [3:0] key_level
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [7:0] DELAY_LAST = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] RATE_LAST  = 8'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

    // Bit order everywhere: [3]=up, [2]=down, [1]=left, [0]=right.
    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    deb;
    logic [DW-1:0] db_cnt [4];

    state_t        state_q [4];
    state_t        state_d [4];
    logic [7:0]    tcnt_q  [4];
    logic [7:0]    tcnt_d  [4];
    logic [3:0]    step_d;
    logic [3:0]    step_q;

    assign raw = {up, down, left, right};

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int k = 0; k < 4; k++) db_cnt[k] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int k = 0; k < 4; k++) begin
                if (sync2[k] == deb[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    deb[k]    <= ~deb[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q <= '0;
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= IDLE;
                tcnt_q[k]  <= '0;
            end
        end else begin
            step_q <= step_d;
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                tcnt_q[k]  <= tcnt_d[k];
            end
        end
    end

    // Release always wins over a coincident frame_tick and never emits a step.
    always_comb begin
        step_d = '0;
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            tcnt_d[k]  = tcnt_q[k];
            case (state_q[k])
                IDLE: begin
                    if (deb[k]) begin
                        state_d[k] = HOLD;
                        tcnt_d[k]  = '0;
                        step_d[k]  = 1'b1;
                    end
                end
                HOLD: begin
                    if (!deb[k]) begin
                        state_d[k] = IDLE;
                        tcnt_d[k]  = '0;
                    end else if (frame_tick) begin
`ifdef KEY_REPEAT_EN
                        if (tcnt_q[k] >= DELAY_LAST) begin
                            state_d[k] = REPEAT;
                            tcnt_d[k]  = '0;
                            step_d[k]  = 1'b1;
                        end else begin
                            tcnt_d[k] = sat_inc(tcnt_q[k]);
                        end
`else
                        tcnt_d[k] = sat_inc(tcnt_q[k]);
`endif
                    end
                end
`ifdef KEY_REPEAT_EN
                REPEAT: begin
                    if (!deb[k]) begin
                        state_d[k] = IDLE;
                        tcnt_d[k]  = '0;
                    end else if (frame_tick) begin
                        if (tcnt_q[k] >= RATE_LAST) begin
                            tcnt_d[k] = '0;
                            step_d[k] = 1'b1;
                        end else begin
                            tcnt_d[k] = sat_inc(tcnt_q[k]);
                        end
                    end
                end
`endif
                default: begin
                    state_d[k] = IDLE;
                    tcnt_d[k]  = '0;
                end
            endcase
        end
    end

    // Opposing keys held together cancel each other's steps; the FSMs keep running underneath.
    logic ud_block;
    logic lr_block;

    assign ud_block   = deb[3] & deb[2];
    assign lr_block   = deb[1] & deb[0];
    assign step_up    = step_q[3] & ~ud_block;
    assign step_down  = step_q[2] & ~ud_block;
    assign step_left  = step_q[1] & ~lr_block;
    assign step_right = step_q[0] & ~lr_block;
    assign key_level  = deb;

endmodule
